ecap5_dwbm_initiator: RTL and testbench
=======================================

ECAP5_DWBM_INITIATOR -- requirements
Module: ecap5_dwbm_initiator

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 256, cycles from strobe assertion to abort when no ack (range 2..65535).
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rst_i  input  1  reset, asynchronous, active-low.
REQ-004 req_valid_i  input  1  command valid.
REQ-005 req_ready_o  output  1  command accepted when high with req_valid_i.
REQ-006 req_we_i  input  1  1 = write, 0 = read.
REQ-007 req_adr_i  input  32  byte address.
REQ-008 req_dat_i  input  32  write data.
REQ-009 req_sel_i  input  4  byte-lane select.
REQ-010 rsp_valid_o  output  1  one-cycle completion pulse.
REQ-011 rsp_dat_o  output  32  read data, valid with rsp_valid_o.
REQ-012 rsp_err_o  output  1  timeout flag, valid with rsp_valid_o.
REQ-013 wb_adr_o, wb_dat_o (32), wb_dat_i (32), wb_we_o, wb_sel_o (4), wb_stb_o, wb_ack_i, wb_cyc_o, wb_stall_i: pipelined Wishbone B4 initiator port, widths matching the memory responder.

Function
REQ-014 FSM states IDLE, REQUEST, WAIT_ACK; one transaction outstanding at most.
REQ-015 req_ready_o = 1 only in IDLE (combinational from state).
REQ-016 IDLE, req_valid_i=1: latch we/adr/dat/sel into wb_* outputs, next state REQUEST, wb_cyc_o=wb_stb_o=1 from next cycle.
REQ-017 REQUEST: wb_stb_o=1 held while wb_stall_i=1; wb_stall_i=0 -> strobe accepted, next state WAIT_ACK, wb_stb_o=0 next cycle.
REQ-018 REQUEST with wb_stall_i=0 and wb_ack_i=1 same cycle -> completion, next state IDLE.
REQ-019 WAIT_ACK: wb_cyc_o=1, wb_stb_o=0; wb_ack_i=1 -> completion, next state IDLE.
REQ-020 Completion: next cycle rsp_valid_o=1 for exactly one cycle, rsp_err_o=0, rsp_dat_o = wb_dat_i sampled with ack (read) or 32'h0 (write); wb_cyc_o=0 that same cycle.
REQ-021 wb_adr_o/wb_dat_o/wb_we_o/wb_sel_o stable from acceptance until return to IDLE; req_adr_i passed unmodified.
REQ-022 Watchdog: counter cleared on acceptance, +1 each cycle in REQUEST/WAIT_ACK; on reaching TIMEOUT_CYCLES-1 without ack -> next state IDLE, wb_cyc_o=wb_stb_o=0, rsp_valid_o=1, rsp_err_o=1, rsp_dat_o=0.
REQ-023 Ack and timeout in same cycle: ack wins, rsp_err_o=0.
REQ-024 wb_ack_i in IDLE ignored; no response generated.
REQ-025 Latency, zero-stall responder acking one cycle after strobe: accept at N, stb N+1, ack N+2, rsp_valid_o N+3; req_ready_o high at N+3, back-to-back acceptance allowed there.
REQ-026 Counter width $clog2(TIMEOUT_CYCLES); no wrap within a transaction.

Reset
REQ-027 rst_i low asynchronously forces: state IDLE, wb_cyc_o=wb_stb_o=wb_we_o=0, wb_adr_o=wb_dat_o=0, wb_sel_o=0, rsp_valid_o=0, rsp_err_o=0, rsp_dat_o=0, counter 0.
REQ-028 Reset mid-transaction: cycle aborted immediately, no rsp_valid_o pulse after release; req_ready_o=1 first cycle after release.

Structure
REQ-029 Package ecap5_dwbm_pkg holds the FSM state typedef and the default TIMEOUT_CYCLES constant.
REQ-030 Watchdog counter is sub-module ecap5_dwbm_watchdog (clear, enable, expired outputs); remainder is one FSM module.

Verification
REQ-031 Write adr=32'h100, dat=32'hDEADBEEF, sel=4'hF, responder no stall -> one stb cycle with those values, rsp_valid_o at N+3, rsp_err_o=0, rsp_dat_o=0.
REQ-032 Read adr=32'h100 after above -> rsp_dat_o=32'hDEADBEEF; sel=4'h3 write of 32'h0000CAFE first then read -> 32'hDEADCAFE.
REQ-033 wb_stall_i high 5 cycles -> wb_stb_o high 6 cycles, outputs stable throughout, single completion.
REQ-034 Responder never acks, TIMEOUT_CYCLES=16 -> wb_cyc_o drops and rsp_valid_o=1, rsp_err_o=1 exactly 16 cycles after acceptance; ack arriving on the expiry cycle -> rsp_err_o=0.
REQ-035 rst_i pulsed low during WAIT_ACK -> wb_cyc_o=0 immediately, no rsp_valid_o, next request completes normally.
REQ-036 Spurious wb_ack_i in IDLE, then 4 back-to-back reads -> no extra responses, exactly 4 rsp_valid_o pulses, correct data order.

Source files
------------

// File: rtl/ecap5_dwbm_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ecap5_dwbm_pkg                                             |
// | Description : Shared types and constants for the Wishbone initiator:     |
// |               FSM state encoding and default watchdog timeout.           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package ecap5_dwbm_pkg;

  // Default number of cycles a strobed cycle may wait for an ack.
  localparam int unsigned c_DEFAULT_TIMEOUT_CYCLES = 256;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQUEST  = 2'd1,
    ST_WAIT_ACK = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/ecap5_dwbm_initiator_if.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ecap5_dwbm_initiator_if                                    |
// | Description : Pipelined Wishbone B4 bus bundle (32-bit data, 4 lanes).   |
// |               Signal names follow the initiator's point of view.         |
// |   master : drives adr/dat_o/we/sel/stb/cyc, receives dat_i/ack/stall     |
// |   slave  : the responder's view of the same bundle                       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface ecap5_dwbm_initiator_if;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic        wb_stb_o;
  logic        wb_ack_i;
  logic        wb_cyc_o;
  logic        wb_stall_i;

  modport master (
    output wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o,
    input  wb_dat_i, wb_ack_i, wb_stall_i
  );

  modport slave (
    input  wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o,
    output wb_dat_i, wb_ack_i, wb_stall_i
  );
endinterface
`default_nettype wire

// File: rtl/ecap5_dwbm_watchdog.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ecap5_dwbm_watchdog                                        |
// | Description : Bus-cycle timeout counter.                                 |
// |   clk_i     : clock                                                      |
// |   rst_i     : asynchronous active-low reset                              |
// |   i_clear   : restart count at 0 (new transaction accepted)              |
// |   i_enable  : count this cycle (transaction outstanding)                 |
// |   o_expired : counter at TIMEOUT_CYCLES-1 while enabled                  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module ecap5_dwbm_watchdog
  import ecap5_dwbm_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = c_DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int unsigned         c_CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [c_CNT_W-1:0]  c_LAST  = c_CNT_W'(TIMEOUT_CYCLES - 1);

  logic [c_CNT_W-1:0] r_count;

  // Saturates at the last value so the count can never wrap inside one
  // transaction, even if the FSM were to linger.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != c_LAST)) begin
      r_count <= r_count + c_CNT_W'(1);
    end
  end

  assign o_expired = i_enable && (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/ecap5_dwbm_initiator.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ecap5_dwbm_initiator                                       |
// | Description : Single-outstanding command-to-Wishbone-B4 (pipelined)      |
// |               initiator with ack watchdog.                               |
// |   clk_i, rst_i (async, active-low)                                       |
// |   req_*  : command handshake (valid/ready, we, adr, dat, sel)            |
// |   rsp_*  : one-cycle completion pulse with read data and timeout flag    |
// |   wb     : Wishbone master modport                                       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module ecap5_dwbm_initiator
  import ecap5_dwbm_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = c_DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic                   req_we_i,
  input  logic [31:0]            req_adr_i,
  input  logic [31:0]            req_dat_i,
  input  logic [3:0]             req_sel_i,
  output logic                   rsp_valid_o,
  output logic [31:0]            rsp_dat_o,
  output logic                   rsp_err_o,
  ecap5_dwbm_initiator_if.master wb
);

  state_e      r_state;
  state_e      w_state_nxt;
  logic        w_accept;
  logic        w_complete;
  logic        w_timeout;
  logic        w_expired;

  logic        r_we;
  logic [31:0] r_adr;
  logic [31:0] r_dat;
  logic [3:0]  r_sel;
  logic        r_rsp_valid;
  logic        r_rsp_err;
  logic [31:0] r_rsp_dat;

  assign req_ready_o = (r_state == ST_IDLE);
  assign w_accept    = req_ready_o && req_valid_i;

  ecap5_dwbm_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .i_clear   (w_accept),
    .i_enable  (r_state != ST_IDLE),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Ack is tested before expiry so an ack landing on the expiry cycle wins.
  // In REQUEST an ack only counts once the strobe itself is taken (no stall).
  always_comb begin
    w_state_nxt = r_state;
    w_complete  = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req_valid_i) w_state_nxt = ST_REQUEST;
      end
      ST_REQUEST: begin
        if (!wb.wb_stall_i && wb.wb_ack_i) begin
          w_complete  = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (w_expired) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (!wb.wb_stall_i) begin
          w_state_nxt = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        if (wb.wb_ack_i) begin
          w_complete  = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (w_expired) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_we        <= 1'b0;
      r_adr       <= '0;
      r_dat       <= '0;
      r_sel       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_dat   <= '0;
    end else begin
      if (w_accept) begin
        r_we  <= req_we_i;
        r_adr <= req_adr_i;
        r_dat <= req_dat_i;
        r_sel <= req_sel_i;
      end
      r_rsp_valid <= w_complete || w_timeout;
      r_rsp_err   <= w_timeout;
      // Read data is captured with the ack; writes and timeouts return zero.
      if (w_complete && !r_we) begin
        r_rsp_dat <= wb.wb_dat_i;
      end else begin
        r_rsp_dat <= '0;
      end
    end
  end

  // cyc/stb decode straight from state so they drop the cycle the FSM
  // returns to IDLE, coincident with the response pulse.
  assign wb.wb_cyc_o = (r_state != ST_IDLE);
  assign wb.wb_stb_o = (r_state == ST_REQUEST);
  assign wb.wb_we_o  = r_we;
  assign wb.wb_adr_o = r_adr;
  assign wb.wb_dat_o = r_dat;
  assign wb.wb_sel_o = r_sel;

  assign rsp_valid_o = r_rsp_valid;
  assign rsp_err_o   = r_rsp_err;
  assign rsp_dat_o   = r_rsp_dat;

endmodule
`default_nettype wire

// File: tb/tb_ecap5_dwbm_initiator.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_ecap5_dwbm_initiator                                    |
// | Description : Scoreboard bench for ecap5_dwbm_initiator with a simple    |
// |               Wishbone memory responder (configurable stall/ack delay).  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_ecap5_dwbm_initiator;

  localparam int unsigned c_TIMEOUT = 16;

  logic        clk;
  logic        rst_n;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [31:0] req_adr_i;
  logic [31:0] req_dat_i;
  logic [3:0]  req_sel_i;
  logic        rsp_valid_o;
  logic [31:0] rsp_dat_o;
  logic        rsp_err_o;

  ecap5_dwbm_initiator_if wb ();

  ecap5_dwbm_initiator #(
    .TIMEOUT_CYCLES (c_TIMEOUT)
  ) u_dut (
    .clk_i       (clk),
    .rst_i       (rst_n),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_we_i    (req_we_i),
    .req_adr_i   (req_adr_i),
    .req_dat_i   (req_dat_i),
    .req_sel_i   (req_sel_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_dat_o   (rsp_dat_o),
    .rsp_err_o   (rsp_err_o),
    .wb          (wb)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc_cnt = 0;
  initial forever begin
    @(posedge clk);
    cyc_cnt++;
  end

  // Scoreboard queues: expected responses and generic named checks.
  logic [31:0] exp_dat_q [$];
  logic        exp_err_q [$];
  int          exp_cyc_q [$];
  string       chk_name_q [$];
  logic [31:0] chk_act_q [$];
  logic [31:0] chk_exp_q [$];

  int n_checks = 0;
  int n_errors = 0;
  int rsp_seen = 0;

  function automatic void push_chk(string name, logic [31:0] act, logic [31:0] exp);
    chk_name_q.push_back(name);
    chk_act_q.push_back(act);
    chk_exp_q.push_back(exp);
  endfunction

  // Responder configuration (written by the stimulus process only)
  int ack_en     = 1;
  int ack_delay  = 1;
  int stall_cfg  = 0;
  int spur_req   = 0;

  // Memory responder: decides bus inputs mid-cycle for the next rising edge.
  logic [31:0] mem [0:15];
  int          spur_done;
  int          wait_cnt;
  int          stall_n;
  logic        p_we;
  logic [31:0] p_adr;
  logic [31:0] p_dat;
  logic [3:0]  p_sel;
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    spur_done = 0;
    wait_cnt  = 0;
    stall_n   = 0;
    p_we = 1'b0; p_adr = '0; p_dat = '0; p_sel = '0;
    wb.wb_ack_i   = 1'b0;
    wb.wb_stall_i = 1'b0;
    wb.wb_dat_i   = 32'hFFFF_FFFF;
    forever begin
      @(negedge clk);
      wb.wb_ack_i = 1'b0;
      wb.wb_dat_i = 32'hFFFF_FFFF;
      if (wait_cnt > 0) begin
        wait_cnt--;
        if (wait_cnt == 0) begin
          wb.wb_ack_i = 1'b1;
          if (p_we) begin
            for (int b = 0; b < 4; b++)
              if (p_sel[b]) mem[p_adr[5:2]][8*b +: 8] = p_dat[8*b +: 8];
          end else begin
            wb.wb_dat_i = mem[p_adr[5:2]];
          end
        end
      end
      if (spur_req != spur_done) begin
        wb.wb_ack_i = 1'b1;
        spur_done++;
      end
      if (wb.wb_cyc_o && wb.wb_stb_o) begin
        if (stall_n < stall_cfg) begin
          wb.wb_stall_i = 1'b1;
          stall_n++;
        end else begin
          wb.wb_stall_i = 1'b0;
          stall_n = 0;
          if (ack_en != 0) begin
            wait_cnt = ack_delay;
            p_we  = wb.wb_we_o;
            p_adr = wb.wb_adr_o;
            p_dat = wb.wb_dat_o;
            p_sel = wb.wb_sel_o;
          end
        end
      end else begin
        wb.wb_stall_i = 1'b0;
        stall_n = 0;
      end
    end
  end

  // Monitor: drains named checks and compares every response pulse.
  string       m_name;
  logic [31:0] m_act;
  logic [31:0] m_exp;
  logic [31:0] m_edat;
  logic        m_eerr;
  int          m_ecyc;
  initial forever begin
    @(negedge clk);
    while (chk_name_q.size() > 0) begin
      m_name = chk_name_q.pop_front();
      m_act  = chk_act_q.pop_front();
      m_exp  = chk_exp_q.pop_front();
      n_checks++;
      if (m_act !== m_exp) begin
        n_errors++;
        $display("FAIL %s: got 0x%08h expected 0x%08h", m_name, m_act, m_exp);
      end
    end
    if (rst_n && rsp_valid_o) begin
      rsp_seen++;
      if (exp_dat_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_rsp: got rsp dat=0x%08h err=%0b at cycle %0d, expected none",
                 rsp_dat_o, rsp_err_o, cyc_cnt);
      end else begin
        m_edat = exp_dat_q.pop_front();
        m_eerr = exp_err_q.pop_front();
        m_ecyc = exp_cyc_q.pop_front();
        n_checks++;
        if (rsp_dat_o !== m_edat) begin
          n_errors++;
          $display("FAIL rsp_dat: got 0x%08h expected 0x%08h", rsp_dat_o, m_edat);
        end
        n_checks++;
        if (rsp_err_o !== m_eerr) begin
          n_errors++;
          $display("FAIL rsp_err: got %0b expected %0b", rsp_err_o, m_eerr);
        end
        n_checks++;
        if (cyc_cnt != m_ecyc) begin
          n_errors++;
          $display("FAIL rsp_cycle: got %0d expected %0d", cyc_cnt, m_ecyc);
        end
        n_checks++;
        if (wb.wb_cyc_o !== 1'b0) begin
          n_errors++;
          $display("FAIL cyc_at_rsp: got %0b expected 0", wb.wb_cyc_o);
        end
      end
    end
  end

  // Issue one command from a falling edge; returns at the falling edge where
  // the response pulse is visible so a follow-up can be back-to-back.
  task automatic do_req(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input logic [31:0] exp_dat,
                        input logic exp_err, input int exp_lat, input int exp_stb,
                        output int acc_cyc);
    int  budget;
    int  stb_n;
    int  unstable;
    bit  done;
    req_we_i    = we;
    req_adr_i   = adr;
    req_dat_i   = dat;
    req_sel_i   = sel;
    req_valid_i = 1'b1;
    budget = 0;
    while (!req_ready_o && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (!req_ready_o) begin
      push_chk("accept_timeout", 32'(req_ready_o), 32'd1);
      req_valid_i = 1'b0;
      acc_cyc = cyc_cnt;
      return;
    end
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
    acc_cyc = cyc_cnt;
    exp_dat_q.push_back(exp_dat);
    exp_err_q.push_back(exp_err);
    exp_cyc_q.push_back(acc_cyc + exp_lat);
    stb_n = 0;
    unstable = 0;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (wb.wb_stb_o) stb_n++;
      if (wb.wb_cyc_o && (wb.wb_adr_o !== adr || wb.wb_we_o !== we ||
                          wb.wb_sel_o !== sel || wb.wb_dat_o !== dat))
        unstable++;
      if (rsp_valid_o) done = 1'b1;
    end
    if (!done) begin
      push_chk("rsp_timeout", 32'd0, 32'd1);
      exp_dat_q.delete();
      exp_err_q.delete();
      exp_cyc_q.delete();
    end
    push_chk("stb_cycles", 32'(stb_n), 32'(exp_stb));
    push_chk("bus_stable", 32'(unstable), 32'd0);
  endtask

  int a0, a1, a2, a3;
  int seen_before;

  initial begin
    rst_n       = 1'b0;
    req_valid_i = 1'b0;
    req_we_i    = 1'b0;
    req_adr_i   = '0;
    req_dat_i   = '0;
    req_sel_i   = '0;
    repeat (3) @(negedge clk);
    push_chk("rst_ctrl", 32'({wb.wb_cyc_o, wb.wb_stb_o, wb.wb_we_o, wb.wb_sel_o,
                              rsp_valid_o, rsp_err_o}), 32'd0);
    push_chk("rst_adr", wb.wb_adr_o, 32'd0);
    push_chk("rst_dat", wb.wb_dat_o, 32'd0);
    push_chk("rst_rsp_dat", rsp_dat_o, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    push_chk("ready_idle", 32'(req_ready_o), 32'd1);

    // Basic write/read, byte-lane merge
    do_req(1'b1, 32'h100, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0, 2, 1, a0);
    do_req(1'b0, 32'h100, 32'h0,        4'hF, 32'hDEADBEEF, 1'b0, 2, 1, a0);
    do_req(1'b1, 32'h100, 32'h0000CAFE, 4'h3, 32'h0,        1'b0, 2, 1, a0);
    do_req(1'b0, 32'h100, 32'h0,        4'hF, 32'hDEADCAFE, 1'b0, 2, 1, a0);

    // Five stall cycles: six strobe cycles, response five cycles later
    stall_cfg = 5;
    do_req(1'b1, 32'h104, 32'h12345678, 4'hF, 32'h0,        1'b0, 7, 6, a0);
    stall_cfg = 0;
    do_req(1'b1, 32'h108, 32'h0BADF00D, 4'hF, 32'h0,        1'b0, 2, 1, a0);

    // Silent responder: abort with error 16 cycles after acceptance
    ack_en = 0;
    do_req(1'b0, 32'h108, 32'h0,        4'hF, 32'h0,        1'b1, 16, 1, a0);
    ack_en = 1;

    // Ack exactly on the expiry cycle wins over the timeout
    ack_delay = 15;
    do_req(1'b0, 32'h104, 32'h0,        4'hF, 32'h12345678, 1'b0, 16, 1, a0);

    // Reset while waiting for ack
    ack_delay = 6;
    @(negedge clk);
    seen_before = rsp_seen;
    req_we_i    = 1'b0;
    req_adr_i   = 32'h100;
    req_dat_i   = 32'h0;
    req_sel_i   = 4'hF;
    req_valid_i = 1'b1;
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    push_chk("pre_rst_wait_ack", 32'({wb.wb_cyc_o, wb.wb_stb_o}), 32'd2);
    rst_n = 1'b0;
    #1;
    push_chk("rst_abort", 32'({wb.wb_cyc_o, wb.wb_stb_o, rsp_valid_o}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push_chk("ready_after_rst", 32'(req_ready_o), 32'd1);
    repeat (8) @(negedge clk);
    push_chk("no_rsp_after_rst", 32'(rsp_seen - seen_before), 32'd0);
    ack_delay = 1;
    do_req(1'b0, 32'h100, 32'h0,        4'hF, 32'hDEADCAFE, 1'b0, 2, 1, a0);

    // Spurious ack in IDLE, then four back-to-back reads
    @(negedge clk);
    seen_before = rsp_seen;
    spur_req++;
    repeat (4) @(negedge clk);
    push_chk("spurious_ack_ignored", 32'(rsp_seen - seen_before), 32'd0);
    seen_before = rsp_seen;
    do_req(1'b0, 32'h100, 32'h0, 4'hF, 32'hDEADCAFE, 1'b0, 2, 1, a0);
    do_req(1'b0, 32'h104, 32'h0, 4'hF, 32'h12345678, 1'b0, 2, 1, a1);
    do_req(1'b0, 32'h108, 32'h0, 4'hF, 32'h0BADF00D, 1'b0, 2, 1, a2);
    do_req(1'b0, 32'h100, 32'h0, 4'hF, 32'hDEADCAFE, 1'b0, 2, 1, a3);
    push_chk("b2b_spacing_1", 32'(a1 - a0), 32'd3);
    push_chk("b2b_spacing_2", 32'(a2 - a1), 32'd3);
    push_chk("b2b_spacing_3", 32'(a3 - a2), 32'd3);
    repeat (3) @(negedge clk);
    push_chk("b2b_rsp_count", 32'(rsp_seen - seen_before), 32'd4);
    push_chk("scoreboard_empty", 32'(exp_dat_q.size()), 32'd0);
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t, expected finish", $time);
    $fatal(1, "bench time limit exceeded");
  end

endmodule
`default_nettype wire
